// File: rtl/fsm_ctx_sched.sv
// Round-robin scheduler that time-multiplexes one 3-state transition step
// across NCTX independent contexts, each with its own state and pending events.
module fsm_ctx_sched #(
  parameter int unsigned NCTX = 4,
  parameter int unsigned W    = 2,
  parameter int unsigned CW   = $clog2(NCTX)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [W-1:0]      c0,
  input  logic [W-1:0]      c1,
  input  logic [W-1:0]      c2,
  input  logic              en,
  input  logic              ev_valid,
  input  logic [CW-1:0]     ev_ctx,
  input  logic [1:0]        ev_sel,
  output logic              ev_ready,
  input  logic [NCTX-1:0]   ctx_rst,
  output logic              upd_valid,
  output logic [CW-1:0]     upd_ctx,
  output logic [W-1:0]      upd_state,
  output logic [NCTX*W-1:0] st_flat
);

  logic [W-1:0]  state    [NCTX];
  logic [2:0]    pend     [NCTX];
  logic [2:0]    pend_nxt [NCTX];
  logic [CW-1:0] rr;

  logic [2:0]    sel_mask;
  logic          accept;
  logic          gnt_vld;
  logic [CW-1:0] gnt;
  logic [CW-1:0] cand;
  logic [W-1:0]  s;
  logic [2:0]    i;
  logic [W-1:0]  m0;
  logic [W-1:0]  m1;
  logic [W-1:0]  m2;

  // One-hot of the requested event; the null event maps to no bit at all.
  always_comb begin
    sel_mask = 3'b000;
    case (ev_sel)
      2'd0:    sel_mask = 3'b001;
      2'd1:    sel_mask = 3'b010;
      2'd2:    sel_mask = 3'b100;
      default: sel_mask = 3'b000;
    endcase
  end

  assign ev_ready = ~|(pend[ev_ctx] & sel_mask);
  assign accept   = ev_valid & ev_ready;

  // Round-robin search starting just after the last granted context.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NCTX; k++) begin
      cand = rr + CW'(k);
      if (en && !gnt_vld && (|pend[cand]) && !ctx_rst[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
    end
  end

  // Shared transition chain; later stages override earlier ones on duplicate codes.
  always_comb begin
    s  = state[gnt];
    i  = pend[gnt];
    m0 = ((s == c0) && i[0]) ? c1 : s;
    m1 = ((s == c1) && i[1]) ? c2 : m0;
    m2 = ((s == c2) && i[2]) ? c0 : m1;
  end

  // A new accept lands after the grant clear, so a same-edge event survives.
  always_comb begin
    for (int unsigned k = 0; k < NCTX; k++) begin
      pend_nxt[k] = pend[k];
      if (gnt_vld && (gnt == CW'(k))) begin
        pend_nxt[k] = 3'b000;
      end
      if (accept && (ev_ctx == CW'(k))) begin
        pend_nxt[k] = pend_nxt[k] | sel_mask;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < NCTX; k++) begin
        state[k] <= c0;
        pend[k]  <= 3'b000;
      end
      rr        <= CW'(NCTX - 1);
      upd_valid <= 1'b0;
      upd_ctx   <= '0;
      upd_state <= c0;
    end else begin
      for (int unsigned k = 0; k < NCTX; k++) begin
        if (ctx_rst[k]) begin
          state[k] <= c0;
          pend[k]  <= 3'b000;
        end else begin
          pend[k] <= pend_nxt[k];
          if (gnt_vld && (gnt == CW'(k))) begin
            state[k] <= m2;
          end
        end
      end
      upd_valid <= gnt_vld;
      if (gnt_vld) begin
        upd_ctx   <= gnt;
        upd_state <= m2;
        rr        <= gnt;
      end
    end
  end

  for (genvar k = 0; k < int'(NCTX); k++) begin : g_flat
    assign st_flat[k*W +: W] = state[k];
  end

endmodule

// File: tb/tb_fsm_ctx_sched.sv
// Directed bench for fsm_ctx_sched: a per-cycle vector table plus a few
// hand sequences for reset with other codes and duplicate-code chaining.
module tb_fsm_ctx_sched;

  logic       clock;
  logic       reset;
  logic [1:0] c0, c1, c2;
  logic       en;
  logic       ev_valid;
  logic [1:0] ev_ctx;
  logic [1:0] ev_sel;
  logic       ev_ready;
  logic [3:0] ctx_rst;
  logic       upd_valid;
  logic [1:0] upd_ctx;
  logic [1:0] upd_state;
  logic [7:0] st_flat;

  int total = 0;
  int bad   = 0;

  fsm_ctx_sched #(.NCTX(4), .W(2)) dut (
    .clock(clock), .reset(reset), .c0(c0), .c1(c1), .c2(c2), .en(en),
    .ev_valid(ev_valid), .ev_ctx(ev_ctx), .ev_sel(ev_sel), .ev_ready(ev_ready),
    .ctx_rst(ctx_rst), .upd_valid(upd_valid), .upd_ctx(upd_ctx),
    .upd_state(upd_state), .st_flat(st_flat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic       v;
    logic [1:0] ctx;
    logic [1:0] sel;
    logic [3:0] rst;
    logic       x_rdy;
    logic       x_uv;
    logic [1:0] x_uctx;
    logic [1:0] x_ust;
    logic [7:0] x_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic v, input logic [1:0] ctx,
                              input logic [1:0] sel, input logic [3:0] rst,
                              input logic rdy, input logic uv, input logic [1:0] uctx,
                              input logic [1:0] ust, input logic [7:0] st);
    vec_t r;
    r.en = e; r.v = v; r.ctx = ctx; r.sel = sel; r.rst = rst;
    r.x_rdy = rdy; r.x_uv = uv; r.x_uctx = uctx; r.x_ust = ust; r.x_st = st;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check ev_ready before the edge.
  task automatic drive(input logic e, input logic v, input logic [1:0] ctx,
                       input logic [1:0] sel, input logic [3:0] rst);
    @(negedge clock);
    en = e; ev_valid = v; ev_ctx = ctx; ev_sel = sel; ctx_rst = rst;
    #1;
  endtask

  task automatic post(input string nm, input logic uv, input logic [1:0] uctx,
                      input logic [1:0] ust, input logic [7:0] st);
    @(posedge clock);
    #1;
    chk({nm, " upd_valid"}, 32'(upd_valid), 32'(uv));
    if (uv) begin
      chk({nm, " upd_ctx"}, 32'(upd_ctx), 32'(uctx));
      chk({nm, " upd_state"}, 32'(upd_state), 32'(ust));
    end
    chk({nm, " st_flat"}, 32'(st_flat), 32'(st));
  endtask

  task automatic do_reset(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                          input logic [7:0] st);
    @(negedge clock);
    reset = 1'b1; c0 = a; c1 = b; c2 = c;
    en = 1'b0; ev_valid = 1'b0; ev_ctx = 2'd0; ev_sel = 2'd3; ctx_rst = 4'h0;
    @(posedge clock);
    #1;
    chk("rst st_flat", 32'(st_flat), 32'(st));
    chk("rst upd_valid", 32'(upd_valid), 32'd0);
    chk("rst upd_ctx", 32'(upd_ctx), 32'd0);
    chk("rst upd_state", 32'(upd_state), 32'(a));
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; c0 = 2'd0; c1 = 2'd1; c2 = 2'd2;
    en = 1'b0; ev_valid = 1'b0; ev_ctx = 2'd0; ev_sel = 2'd3; ctx_rst = 4'h0;

    //                 en  v  ctx   sel   rst   rdy uv uctx  ust   st
    vecs.push_back(mk(1, 1, 2'd1, 2'd0, 4'h0, 1, 0, 2'd0, 2'd0, 8'h00));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 1, 2'd1, 2'd1, 8'h04));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 0, 2'd0, 2'd0, 8'h04));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h2, 1, 0, 2'd0, 2'd0, 8'h00));
    // burst into all contexts
    vecs.push_back(mk(1, 1, 2'd0, 2'd0, 4'h0, 1, 0, 2'd0, 2'd0, 8'h00));
    vecs.push_back(mk(1, 1, 2'd1, 2'd0, 4'h0, 1, 1, 2'd0, 2'd1, 8'h01));
    vecs.push_back(mk(1, 1, 2'd2, 2'd0, 4'h0, 1, 1, 2'd1, 2'd1, 8'h05));
    vecs.push_back(mk(1, 1, 2'd3, 2'd0, 4'h0, 1, 1, 2'd2, 2'd1, 8'h15));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 1, 2'd3, 2'd1, 8'h55));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 0, 2'd0, 2'd0, 8'h55));
    // non-matching event on ctx2
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h4, 1, 0, 2'd0, 2'd0, 8'h45));
    vecs.push_back(mk(1, 1, 2'd2, 2'd1, 4'h0, 1, 0, 2'd0, 2'd0, 8'h45));
    vecs.push_back(mk(1, 1, 2'd2, 2'd1, 4'h0, 0, 1, 2'd2, 2'd0, 8'h45));
    vecs.push_back(mk(1, 1, 2'd2, 2'd1, 4'h0, 1, 0, 2'd0, 2'd0, 8'h45));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 1, 2'd2, 2'd0, 8'h45));
    // backpressure with en low
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h8, 1, 0, 2'd0, 2'd0, 8'h05));
    vecs.push_back(mk(0, 1, 2'd3, 2'd0, 4'h0, 1, 0, 2'd0, 2'd0, 8'h05));
    vecs.push_back(mk(0, 1, 2'd3, 2'd0, 4'h0, 0, 0, 2'd0, 2'd0, 8'h05));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 1, 2'd3, 2'd1, 8'h45));
    // full cycle on ctx0
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h1, 1, 0, 2'd0, 2'd0, 8'h44));
    vecs.push_back(mk(1, 1, 2'd0, 2'd0, 4'h0, 1, 0, 2'd0, 2'd0, 8'h44));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 1, 2'd0, 2'd1, 8'h45));
    vecs.push_back(mk(1, 1, 2'd0, 2'd1, 4'h0, 1, 0, 2'd0, 2'd0, 8'h45));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 1, 2'd0, 2'd2, 8'h46));
    vecs.push_back(mk(1, 1, 2'd0, 2'd2, 4'h0, 1, 0, 2'd0, 2'd0, 8'h46));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 1, 2'd0, 2'd0, 8'h44));
    // ctx_rst collides with a pending ctx1 and a new event
    vecs.push_back(mk(0, 1, 2'd1, 2'd0, 4'h0, 1, 0, 2'd0, 2'd0, 8'h44));
    vecs.push_back(mk(1, 1, 2'd1, 2'd1, 4'h2, 1, 0, 2'd0, 2'd0, 8'h40));
    vecs.push_back(mk(1, 1, 2'd1, 2'd0, 4'h0, 1, 0, 2'd0, 2'd0, 8'h40));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 1, 2'd1, 2'd1, 8'h44));
    // accept on the grant edge of the same context survives the clear
    vecs.push_back(mk(0, 1, 2'd2, 2'd0, 4'h0, 1, 0, 2'd0, 2'd0, 8'h44));
    vecs.push_back(mk(1, 1, 2'd2, 2'd1, 4'h0, 1, 1, 2'd2, 2'd1, 8'h54));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 1, 2'd2, 2'd2, 8'h64));
    // null event is accepted and dropped
    vecs.push_back(mk(1, 1, 2'd0, 2'd3, 4'h0, 1, 0, 2'd0, 2'd0, 8'h64));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 0, 2'd0, 2'd0, 8'h64));
    // contention: grants rotate 3,0,1 from rr=2
    vecs.push_back(mk(0, 1, 2'd0, 2'd0, 4'h0, 1, 0, 2'd0, 2'd0, 8'h64));
    vecs.push_back(mk(0, 1, 2'd1, 2'd1, 4'h0, 1, 0, 2'd0, 2'd0, 8'h64));
    vecs.push_back(mk(0, 1, 2'd3, 2'd1, 4'h0, 1, 0, 2'd0, 2'd0, 8'h64));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 1, 2'd3, 2'd2, 8'hA4));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 1, 2'd0, 2'd1, 8'hA5));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 1, 2'd1, 2'd2, 8'hA9));
    vecs.push_back(mk(1, 0, 2'd0, 2'd3, 4'h0, 1, 0, 2'd0, 2'd0, 8'hA9));

    do_reset(2'd0, 2'd1, 2'd2, 8'h00);

    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n].en, vecs[n].v, vecs[n].ctx, vecs[n].sel, vecs[n].rst);
      chk($sformatf("v%0d ev_ready", n), 32'(ev_ready), 32'(vecs[n].x_rdy));
      post($sformatf("v%0d", n), vecs[n].x_uv, vecs[n].x_uctx, vecs[n].x_ust, vecs[n].x_st);
    end

    // Non-default codes: c0=3 so every context resets to 3.
    do_reset(2'd3, 2'd1, 2'd0, 8'hFF);
    drive(1'b1, 1'b1, 2'd2, 2'd0, 4'h0);
    post("alt accept", 1'b0, 2'd0, 2'd0, 8'hFF);
    drive(1'b1, 1'b0, 2'd0, 2'd3, 4'h0);
    post("alt step", 1'b1, 2'd2, 2'd1, 8'hDF);

    // Duplicate codes c0==c1: i0 and i1 together chain 1 -> 2.
    do_reset(2'd1, 2'd1, 2'd2, 8'h55);
    drive(1'b0, 1'b1, 2'd0, 2'd0, 4'h0);
    post("dup ev0", 1'b0, 2'd0, 2'd0, 8'h55);
    drive(1'b0, 1'b1, 2'd0, 2'd1, 4'h0);
    chk("dup ev1 ready", 32'(ev_ready), 32'd1);
    post("dup ev1", 1'b0, 2'd0, 2'd0, 8'h55);
    drive(1'b1, 1'b0, 2'd0, 2'd3, 4'h0);
    post("dup chain", 1'b1, 2'd0, 2'd2, 8'h56);
    // i0 alone on a c0==c1 state lands on c1: pulse with unchanged state.
    drive(1'b1, 1'b1, 2'd1, 2'd0, 4'h0);
    post("dup ev ctx1", 1'b0, 2'd0, 2'd0, 8'h56);
    drive(1'b1, 1'b0, 2'd0, 2'd3, 4'h0);
    post("dup same", 1'b1, 2'd1, 2'd1, 8'h56);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
